// File: rtl/sram_sequencer.sv
// Converts a single-cycle valid/ready request into a multi-phase async SRAM bus cycle
// (setup / access / hold), with every SRAM-side control driven straight from a flop.
module sram_sequencer #(
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWr,
  input  logic [17:0] reqAddr,
  input  logic [15:0] reqData,
  input  logic [1:0]  reqMask,
  output logic        rspValid,
  output logic [15:0] rspData,
  output logic [17:0] sramAddr,
  output logic [15:0] dqOut,
  output logic        dqOe,
  input  logic [15:0] dqIn,
  output logic        sramCeN,
  output logic        sramWeN,
  output logic        sramOeN,
  output logic        sramUbN,
  output logic        sramLbN
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  // Phase counter reload values: each phase counts N-1 down to 0.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] ACCESS_LD = 4'(ACCESS_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t     state;
  logic [3:0] phase_cnt;
  logic       lat_wr;
  logic [1:0] lat_mask;

  assign reqReady = (state == IDLE) && !rst;

  // sramAddr and dqOut double as the latched request address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= 4'd0;
      lat_wr    <= 1'b0;
      lat_mask  <= 2'b00;
      sramCeN   <= 1'b1;
      sramWeN   <= 1'b1;
      sramOeN   <= 1'b1;
      sramUbN   <= 1'b1;
      sramLbN   <= 1'b1;
      dqOe      <= 1'b0;
      rspValid  <= 1'b0;
      sramAddr  <= 18'd0;
      dqOut     <= 16'd0;
      rspData   <= 16'd0;
    end else begin
      rspValid <= 1'b0;
      case (state)
        IDLE: begin
          if (reqValid) begin
            state     <= SETUP;
            phase_cnt <= SETUP_LD;
            lat_wr    <= reqWr;
            lat_mask  <= reqMask;
            sramAddr  <= reqAddr;
            sramCeN   <= 1'b0;
            if (reqWr) begin
              dqOe  <= 1'b1;
              dqOut <= reqData;
            end
          end
        end
        SETUP: begin
          if (phase_cnt == 4'd0) begin
            state     <= ACCESS;
            phase_cnt <= ACCESS_LD;
            if (lat_wr) begin
              sramWeN <= 1'b0;
              sramUbN <= ~lat_mask[1];
              sramLbN <= ~lat_mask[0];
            end else begin
              sramOeN <= 1'b0;
              sramUbN <= 1'b0;
              sramLbN <= 1'b0;
            end
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        ACCESS: begin
          if (phase_cnt == 4'd0) begin
            state     <= HOLD;
            phase_cnt <= HOLD_LD;
            sramWeN   <= 1'b1;
            sramOeN   <= 1'b1;
            sramUbN   <= 1'b1;
            sramLbN   <= 1'b1;
            if (!lat_wr) begin
              rspData  <= dqIn;
              rspValid <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        HOLD: begin
          if (phase_cnt == 4'd0) begin
            state   <= IDLE;
            sramCeN <= 1'b1;
            dqOe    <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_sequencer.md
# sram_sequencer

- Downstream stage between the memory-request master (JTAG memory controller today, processor core later) and the board's 512 KB SRAM chip.
- Converts a single-cycle valid/ready request into a multi-cycle SRAM bus cycle with programmable setup, access and hold phases. Returns read data with a one-cycle valid pulse.
- All SRAM-side controls are registered, which removes the clock-gated byte-mask glitches seen with direct decode.
- The chassis owns the `SRAM_DQ` tristate: `SRAM_DQ = dqOe ? dqOut : 'z`.

## Interface
Parameters:
- `SETUP_CYC`, default 1: cycles with address/CE valid before the strobe. Legal range is 1–15.
- `ACCESS_CYC`, default 2: cycles the WE_N/OE_N strobe is held low. Legal range is 1–15.
- `HOLD_CYC`, default 1: cycles with address/data held after the strobe. Legal range is 1–15.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: active-high reset, synchronous to `clk`.
- `reqValid` in 1: a request is present.
- `reqReady` out 1: the block can accept a request.
- `reqWr` in 1: 1 = write, 0 = read.
- `reqAddr` in 18: word address.
- `reqData` in 16: write data.
- `reqMask` in 2: byte enables for writes; [1] = upper byte, [0] = lower byte.
- `rspValid` out 1: one-cycle pulse when `rspData` holds valid read data.
- `rspData` out 16: read data.
- `sramAddr` out 18: to `SRAM_ADDR`.
- `dqOut` out 16: write data to the tristate.
- `dqOe` out 1: tristate enable.
- `dqIn` in 16: from `SRAM_DQ`.
- `sramCeN`, `sramWeN`, `sramOeN`, `sramUbN`, `sramLbN` out 1 each: active-low SRAM controls.

## Operation
**States:** IDLE → SETUP → ACCESS → HOLD → IDLE. A single 4-bit phase counter is reloaded on each state entry.

**Accept rule**
- A request is accepted on a `clk` edge where `reqValid && reqReady`.
- On accept, `reqWr`, `reqAddr`, `reqData` and `reqMask` are latched. Input changes after the accept edge are ignored.

**IDLE**
- `reqReady` = 1.
- All controls are inactive (high), `dqOe` = 0.
- `sramAddr` and `dqOut` keep their last values.
- Accept moves the FSM to SETUP.

**SETUP** (`SETUP_CYC` cycles)
- `sramCeN` = 0 and `sramAddr` = latched address.
- `sramWeN` = 1 and `sramOeN` = 1.
- `sramUbN` and `sramLbN` = 1.
- For a write, `dqOe` = 1 and `dqOut` = latched data.

**ACCESS** (`ACCESS_CYC` cycles)
- Write:
  - `sramWeN` = 0.
  - `sramUbN` = ~mask[1] and `sramLbN` = ~mask[0].
  - Mask 00 still runs the full cycle but writes nothing.
- Read:
  - `sramOeN` = 0.
  - `sramUbN` and `sramLbN` = 0.
  - `dqOe` = 0.
  - `dqIn` is captured into `rspData` on the edge that ends the last ACCESS cycle.

**HOLD** (`HOLD_CYC` cycles)
- `sramWeN` = 1, `sramOeN` = 1, `sramUbN` = 1, `sramLbN` = 1.
- `sramCeN` = 0 and `sramAddr` stay unchanged.
- For a write, `dqOe` stays 1.
- For a read, `rspValid` = 1 during the first HOLD cycle only.

**Sequencing**
- `reqReady` = 0 in every state except IDLE. A `reqValid` asserted while busy waits and is not lost.
- No pipelining: the minimum request period is 1 + `SETUP_CYC` + `ACCESS_CYC` + `HOLD_CYC` cycles.
- `rspData` holds its value until the next read capture.

## Timing
**Output generation**
- All SRAM-side outputs, `rspValid` and `rspData` are driven directly by flops whose next value comes from the next state.
- They change only at rising `clk`, with no combinational path from inputs.
- `reqReady` is decoded from the state register (state == IDLE and not `rst`).

**Example, default parameters (S=1, A=2, H=1), accept at edge 0**

| Cycle | Phase | Read | Write |
|---|---|---|---|
| 1 | SETUP | | |
| 2–3 | ACCESS | Capture at edge ending cycle 3 | `sramWeN` low |
| 4 | HOLD | `rspValid` = 1 | `dqOe` still 1 |
| 5 | IDLE | `reqReady` = 1 | `reqReady` = 1 |

- General read latency from the accept edge to `rspValid`: S + A + 1 cycles.
- `dqOe` is high from the first SETUP cycle through the last HOLD cycle. Data is therefore stable one or more cycles before and after the WE_N strobe.

**Reset** (`rst` = 1 at a `clk` edge)
- Next state is IDLE.
- `sramCeN`, `sramWeN`, `sramOeN`, `sramUbN`, `sramLbN` = 1.
- `dqOe` = 0, `rspValid` = 0.
- `sramAddr` = 0, `dqOut` = 0, `rspData` = 0.
- `reqReady` = 0 while `rst` is high.

**Reset mid-operation**
- The cycle is aborted and all controls are deasserted at the next edge.
- No `rspValid` is produced.
- A write aborted during ACCESS may be partially written; this is accepted.
- A request with `reqValid` high in the same cycle as `rst` is not accepted.

**Phase counter**
- It counts down from N−1 to 0 and advances the state at 0.
- It never wraps, because all phase lengths are at least 1.

## Test plan
1. **Reset values:** hold `rst` 3 cycles, then release.
   - During reset: every control = 1, `dqOe` = 0, `rspValid` = 0, `reqReady` = 0.
   - First cycle after release: `reqReady` = 1.
2. **Write, default parameters:** `reqWr` = 1, addr 0x00123, data 0xBEEF, mask 11.
   - `sramWeN` low in exactly cycles 2–3.
   - `dqOe` high in cycles 1–4 with `dqOut` = 0xBEEF.
   - The SRAM model holds 0xBEEF at 0x00123.
3. **Read back and byte mask:**
   - Read 0x00123: `rspValid` in cycle 4 with `rspData` = 0xBEEF.
   - Write 0x1200 with mask 10, then read: result is 0x12EF.
4. **Busy handling:** hold `reqValid` high across two back-to-back requests (a write, then a read).
   - The second request is accepted at edge 5, not earlier.
   - `reqReady` is 0 in cycles 1–4.
5. **Reset mid-operation:** assert `rst` in cycle 2 of a read.
   - Next cycle: all controls high.
   - No `rspValid` pulse follows.
   - The next request completes normally.
6. **Parameter sweep:** S=3, A=1, H=2.
   - `rspValid` at accept + 5.
   - `reqReady` returns at accept + 7.
